// File: rtl/csr_pkg.sv
// csr_pkg: shared constants and types for the machine-mode trap sequencer.
//   - CSR addresses for mstatus, mie, mepc and mip
//   - bit positions of the enable/pending fields the sequencer touches
//   - trap_state_e, the sequencer state encoding
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_EPC   = 3'd1,
    ST_WR_MIP   = 3'd2,
    ST_WR_STAT  = 3'd3,
    ST_RD_EPC   = 3'd4,
    ST_RET_STAT = 3'd5,
    ST_REDIR    = 3'd6
  } trap_state_e;

endpackage

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: trap/interrupt sequencer and owner of the CSR file write port.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   irq_timer, irq_ext         level interrupt requests
//   mret_i, pc_i               mret strobe from EX, resume PC (mepc value)
//   pipe_csr_req/addr/wdata    pipeline CSR access; pipe_csr_gnt = write done
//   csr_addr_o/wdata_o/we_o    CSR file port; csr_rdata_i = async read data
//   stall_o                    freeze the pipeline
//   redirect_o, redirect_pc_o  one-cycle PC redirect and its target
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | pipeline owns the CSR port; watch for mret / interrupt
// ST_WR_EPC   | write latched PC to mepc
// ST_WR_MIP   | write latched pending bits to mip
// ST_WR_STAT  | mstatus: MPIE <= MIE, MIE <= 0
// ST_RD_EPC   | read mepc as the return target
// ST_RET_STAT | mstatus: MIE <= MPIE, MPIE <= 1
// ST_REDIR    | pulse redirect to target, then back to idle
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        irq_timer,
  input  logic        irq_ext,
  input  logic        mret_i,
  input  logic [31:0] pc_i,
  input  logic        pipe_csr_req,
  input  logic [11:0] pipe_csr_addr,
  input  logic [31:0] pipe_csr_wdata,
  output logic        pipe_csr_gnt,
  output logic [11:0] csr_addr_o,
  output logic [31:0] csr_wdata_o,
  output logic        csr_we_o,
  input  logic [31:0] csr_rdata_i,
  output logic        stall_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o
);

  trap_state_e state, state_nxt;

  logic [31:0] sh_mstatus;
  // Only the two enable bits of mie influence this block, so only they are kept.
  logic        sh_mtie, sh_meie;
  logic [31:0] lat_pc;
  logic        lat_ext, lat_timer;
  logic [31:0] target;
  logic        take_irq;

  assign take_irq = sh_mstatus[MSTATUS_MIE] &
                    ((irq_timer & sh_mtie) | (irq_ext & sh_meie));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sh_mstatus <= '0;
      sh_mtie    <= 1'b0;
      sh_meie    <= 1'b0;
      lat_pc     <= '0;
      lat_ext    <= 1'b0;
      lat_timer  <= 1'b0;
      target     <= '0;
    end else begin
      state <= state_nxt;
      // Shadows follow every write leaving this block, pipeline or sequencer.
      if (csr_we_o && csr_addr_o == CSR_MSTATUS) sh_mstatus <= csr_wdata_o;
      if (csr_we_o && csr_addr_o == CSR_MIE) begin
        sh_mtie <= csr_wdata_o[MIE_MTIE];
        sh_meie <= csr_wdata_o[MIE_MEIE];
      end
      if (state == ST_IDLE && !mret_i && take_irq) begin
        lat_pc    <= pc_i;
        lat_ext   <= irq_ext;
        lat_timer <= irq_timer;
        target    <= MTVEC;
      end
      if (state == ST_RD_EPC) target <= csr_rdata_i;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (mret_i)        state_nxt = ST_RD_EPC;
        else if (take_irq) state_nxt = ST_WR_EPC;
      end
      ST_WR_EPC:   state_nxt = ST_WR_MIP;
      ST_WR_MIP:   state_nxt = ST_WR_STAT;
      ST_WR_STAT:  state_nxt = ST_REDIR;
      ST_RD_EPC:   state_nxt = ST_RET_STAT;
      ST_RET_STAT: state_nxt = ST_REDIR;
      ST_REDIR:    state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    csr_addr_o    = pipe_csr_addr;
    csr_wdata_o   = '0;
    csr_we_o      = 1'b0;
    pipe_csr_gnt  = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    stall_o       = 1'b1;
    case (state)
      ST_IDLE: begin
        stall_o = mret_i | take_irq;
        if (!mret_i && !take_irq && pipe_csr_req) begin
          csr_we_o     = 1'b1;
          csr_wdata_o  = pipe_csr_wdata;
          pipe_csr_gnt = 1'b1;
        end
      end
      ST_WR_EPC: begin
        csr_addr_o  = CSR_MEPC;
        csr_wdata_o = lat_pc;
        csr_we_o    = 1'b1;
      end
      ST_WR_MIP: begin
        csr_addr_o  = CSR_MIP;
        csr_wdata_o = {20'b0, lat_ext, 3'b0, lat_timer, 7'b0};
        csr_we_o    = 1'b1;
      end
      ST_WR_STAT: begin
        csr_addr_o                = CSR_MSTATUS;
        csr_wdata_o               = sh_mstatus;
        csr_wdata_o[MSTATUS_MPIE] = sh_mstatus[MSTATUS_MIE];
        csr_wdata_o[MSTATUS_MIE]  = 1'b0;
        csr_we_o                  = 1'b1;
      end
      ST_RD_EPC: begin
        csr_addr_o = CSR_MEPC;
      end
      ST_RET_STAT: begin
        csr_addr_o                = CSR_MSTATUS;
        csr_wdata_o               = sh_mstatus;
        csr_wdata_o[MSTATUS_MIE]  = sh_mstatus[MSTATUS_MPIE];
        csr_wdata_o[MSTATUS_MPIE] = 1'b1;
        csr_we_o                  = 1'b1;
      end
      ST_REDIR: begin
        redirect_o    = 1'b1;
        redirect_pc_o = target;
      end
      default: stall_o = 1'b0;
    endcase
  end

endmodule
